// File: rtl/connect4_turn_ctrl.sv
// rtl/connect4_turn_ctrl.sv - Connect4 round-robin turn and game-state controller
// Optional per-turn timeout is compiled in by defining TURN_TIMEOUT_EN.
module connect4_turn_ctrl #(
  parameter int NUM_PLAYERS    = 2,
  parameter int COLS           = 7,
  parameter int ROWS           = 6,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int PW    = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
  localparam int COL_W = $clog2(COLS),
  localparam int CNT_W = $clog2(ROWS*COLS+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             move_valid,
  input  logic [COL_W-1:0] move_col,
  output logic             move_ready,
  output logic             move_reject,
  output logic             drop_req,
  output logic [COL_W-1:0] drop_col,
  output logic [PW-1:0]    drop_player,
  input  logic             eval_valid,
  input  logic [1:0]       eval_result,
  output logic [1:0]       state,
  output logic [PW-1:0]    current_player,
  output logic [CNT_W-1:0] turn_count,
  output logic [PW-1:0]    winner,
  output logic             tie,
  output logic             game_over,
  output logic             timeout_pulse
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_TURN = 2'b01, S_EVAL = 2'b10, S_OVER = 2'b11} state_t;

  localparam logic [1:0]       RES_NEXT    = 2'b00;
  localparam logic [1:0]       RES_WIN     = 2'b01;
  localparam logic [1:0]       RES_TIE     = 2'b10;
  localparam logic [COL_W:0]   COL_LIMIT   = (COL_W+1)'(COLS);
  localparam logic [CNT_W-1:0] CELLS       = CNT_W'(ROWS*COLS);
  localparam logic [PW-1:0]    LAST_PLAYER = PW'(NUM_PLAYERS-1);

  state_t             cur, nxt;
  logic               handshake, col_ok, expire;
  logic [CNT_W-1:0]   count_inc;
  logic [PW-1:0]      player_inc;
  logic               n_reject, n_drop_req, n_tie, n_timeout;
  logic [COL_W-1:0]   n_drop_col;
  logic [PW-1:0]      n_drop_player, n_player, n_winner;
  logic [CNT_W-1:0]   n_count;

  assign handshake  = move_valid & move_ready;
  assign col_ok     = {1'b0, move_col} < COL_LIMIT;
  assign count_inc  = turn_count + CNT_W'(1);
  // Explicit wrap so 3 players never visit encoding 3.
  assign player_inc = (current_player == LAST_PLAYER) ? '0 : current_player + PW'(1);
  assign state      = cur;

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] timer;

  // Handshake in the expiry cycle takes priority over the timeout.
  assign expire = (cur == S_TURN) && !handshake && (timer == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       timer <= '0;
    else if (cur != S_TURN || expire) timer <= '0;
    else                             timer <= timer + TW'(1);
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur            <= S_IDLE;
      move_ready     <= 1'b0;
      move_reject    <= 1'b0;
      drop_req       <= 1'b0;
      drop_col       <= '0;
      drop_player    <= '0;
      current_player <= '0;
      turn_count     <= '0;
      winner         <= '0;
      tie            <= 1'b0;
      game_over      <= 1'b0;
      timeout_pulse  <= 1'b0;
    end else begin
      cur            <= nxt;
      move_ready     <= (nxt == S_TURN);
      move_reject    <= n_reject;
      drop_req       <= n_drop_req;
      drop_col       <= n_drop_col;
      drop_player    <= n_drop_player;
      current_player <= n_player;
      turn_count     <= n_count;
      winner         <= n_winner;
      tie            <= n_tie;
      game_over      <= (nxt == S_OVER);
      timeout_pulse  <= n_timeout;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE, S_OVER: if (start) nxt = S_TURN;
      S_TURN:         if (handshake && col_ok) nxt = S_EVAL;
      S_EVAL: begin
        if (eval_valid) begin
          case (eval_result)
            RES_NEXT: nxt = (count_inc == CELLS) ? S_OVER : S_TURN;
            RES_WIN,
            RES_TIE:  nxt = S_OVER;
            default:  nxt = S_TURN;
          endcase
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    n_reject      = 1'b0;
    n_drop_req    = 1'b0;
    n_timeout     = 1'b0;
    n_drop_col    = drop_col;
    n_drop_player = drop_player;
    n_player      = current_player;
    n_count       = turn_count;
    n_winner      = winner;
    n_tie         = tie;
    case (cur)
      S_IDLE, S_OVER: begin
        if (start) begin
          n_player = '0;
          n_count  = '0;
          n_winner = '0;
          n_tie    = 1'b0;
        end
      end
      S_TURN: begin
        if (handshake) begin
          if (col_ok) begin
            n_drop_req    = 1'b1;
            n_drop_col    = move_col;
            n_drop_player = current_player;
          end else begin
            n_reject = 1'b1;
          end
        end else if (expire) begin
          n_timeout = 1'b1;
          n_player  = player_inc;
        end
      end
      S_EVAL: begin
        if (eval_valid) begin
          case (eval_result)
            RES_NEXT: begin
              n_count = count_inc;
              if (count_inc == CELLS) n_tie = 1'b1;
              else                    n_player = player_inc;
            end
            RES_WIN: begin
              n_count  = count_inc;
              n_winner = drop_player;
            end
            RES_TIE: begin
              n_count = count_inc;
              n_tie   = 1'b1;
            end
            default: n_reject = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_connect4_turn_ctrl.sv
// tb/tb_connect4_turn_ctrl.sv - self-checking bench for connect4_turn_ctrl
module tb_connect4_turn_ctrl;
  localparam int NP = 3;
  localparam int COLS = 7;
  localparam int ROWS = 2;
  localparam int TO = 5;
`ifdef TURN_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, move_valid = 1'b0, eval_valid = 1'b0;
  logic [2:0] move_col = '0;
  logic [1:0] eval_result = '0;
  logic       move_ready, move_reject, drop_req, tie, game_over, timeout_pulse;
  logic [2:0] drop_col;
  logic [1:0] drop_player, current_player, winner, state;
  logic [3:0] turn_count;

  int checks = 0;
  int failures = 0;

  int m_state, m_player, m_count, m_winner, m_tie, m_col, m_dplayer, m_req, m_rej, m_to, m_timer;

  connect4_turn_ctrl #(.NUM_PLAYERS(NP), .COLS(COLS), .ROWS(ROWS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .move_reject(move_reject), .drop_req(drop_req), .drop_col(drop_col),
    .drop_player(drop_player), .eval_valid(eval_valid), .eval_result(eval_result), .state(state),
    .current_player(current_player), .turn_count(turn_count), .winner(winner), .tie(tie),
    .game_over(game_over), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  logic [20:0] dut_vec;
  assign dut_vec = {state, move_ready, move_reject, drop_req, drop_col, drop_player,
                    current_player, turn_count, winner, tie, game_over, timeout_pulse};

  function automatic logic [20:0] model_vec();
    return {2'(m_state), m_state == 1, 1'(m_rej), 1'(m_req), 3'(m_col), 2'(m_dplayer),
            2'(m_player), 4'(m_count), 2'(m_winner), 1'(m_tie), m_state == 3, 1'(m_to)};
  endfunction

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_player = 0; m_count = 0; m_winner = 0; m_tie = 0;
    m_col = 0; m_dplayer = 0; m_req = 0; m_rej = 0; m_to = 0; m_timer = 0;
  endtask

  // Game rules: round-robin players, disc count, verdict handling.
  task automatic model_step(input int s, input int mv, input int col, input int ev, input int res);
    int prev;
    prev = m_state;
    m_req = 0; m_rej = 0; m_to = 0;
    case (m_state)
      0, 3: if (s != 0) begin
        m_state = 1; m_player = 0; m_count = 0; m_winner = 0; m_tie = 0;
      end
      1: begin
        if (mv != 0) begin
          if (col < COLS) begin
            m_col = col; m_dplayer = m_player; m_req = 1; m_state = 2;
          end else m_rej = 1;
        end else if (TIMEOUT_ON && m_timer == TO - 1) begin
          m_to = 1; m_player = (m_player + 1) % NP;
        end
      end
      2: if (ev != 0) begin
        if (res == 3) begin
          m_rej = 1; m_state = 1;
        end else begin
          m_count++;
          if (res == 1) begin
            m_winner = m_dplayer; m_state = 3;
          end else if (res == 2 || m_count == ROWS * COLS) begin
            m_tie = 1; m_state = 3;
          end else begin
            m_player = (m_player + 1) % NP; m_state = 1;
          end
        end
      end
      default: ;
    endcase
    m_timer = (prev == 1 && m_to == 0) ? m_timer + 1 : 0;
  endtask

  task automatic cycle(input int s, input int mv, input int col, input int ev, input int res);
    start = 1'(s); move_valid = 1'(mv); move_col = 3'(col); eval_valid = 1'(ev); eval_result = 2'(res);
    @(posedge clk);
    model_step(s, mv, col, ev, res);
    #1;
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++;
      $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, dut_vec, model_vec());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; move_valid = 0; eval_valid = 0; move_col = '0; eval_result = '0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check("reset_outputs", int'(dut_vec), 0);
    reset = 1'b0;
  endtask

  typedef struct {
    int s, mv, col, ev, res;
    int e_state, e_player, e_count, e_req, e_rej, e_col;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 3, 0, 0, 2, 0, 0, 1, 0, 3};
    tbl[2]  = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 3};
    tbl[3]  = '{0, 1, 7, 0, 0, 1, 1, 1, 0, 1, 3};
    tbl[4]  = '{0, 1, 0, 0, 0, 2, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 3, 1, 1, 1, 0, 1, 0};
    tbl[6]  = '{0, 1, 6, 0, 0, 2, 1, 1, 1, 0, 6};
    tbl[7]  = '{1, 0, 0, 1, 0, 1, 2, 2, 0, 0, 6};
    tbl[8]  = '{0, 1, 2, 1, 1, 2, 2, 2, 1, 0, 2};
    tbl[9]  = '{0, 1, 5, 1, 0, 1, 0, 3, 0, 0, 2};
    tbl[10] = '{1, 0, 0, 0, 0, 1, 0, 3, 0, 0, 2};

    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].s, tbl[i].mv, tbl[i].col, tbl[i].ev, tbl[i].res);
      check($sformatf("tbl%0d_state", i), int'(state), tbl[i].e_state);
      check($sformatf("tbl%0d_player", i), int'(current_player), tbl[i].e_player);
      check($sformatf("tbl%0d_count", i), int'(turn_count), tbl[i].e_count);
      check($sformatf("tbl%0d_drop_req", i), int'(drop_req), tbl[i].e_req);
      check($sformatf("tbl%0d_reject", i), int'(move_reject), tbl[i].e_rej);
      check($sformatf("tbl%0d_drop_col", i), int'(drop_col), tbl[i].e_col);
    end

    // WIN for player 1 on its 4th move (game turn index 10)
    do_reset();
    cycle(1, 0, 0, 0, 0);
    for (int t = 0; t < 10; t++) begin
      cycle(0, 1, t % COLS, 0, 0);
      cycle(0, 0, 0, 1, 0);
    end
    cycle(0, 1, 3, 0, 0);
    check("win_player_before", int'(drop_player), 1);
    cycle(0, 0, 0, 1, 1);
    check("win_state", int'(state), 3);
    check("win_winner", int'(winner), 1);
    check("win_tie", int'(tie), 0);
    check("win_count", int'(turn_count), 11);
    check("win_game_over", int'(game_over), 1);
    cycle(0, 1, 2, 1, 0);
    cycle(0, 1, 4, 0, 0);
    check("over_ignores_move", int'(state), 3);
    check("over_no_drop", int'(drop_req), 0);
    cycle(1, 0, 0, 0, 0);
    check("restart_state", int'(state), 1);
    check("restart_player", int'(current_player), 0);
    check("restart_count", int'(turn_count), 0);
    check("restart_winner", int'(winner), 0);

    // Fill the board with back-to-back minimum-length turns
    do_reset();
    cycle(1, 0, 0, 0, 0);
    for (int t = 0; t < ROWS * COLS; t++) begin
      cycle(0, 1, t % COLS, 0, 0);
      cycle(0, 0, 0, 1, 0);
    end
    check("fill_tie", int'(tie), 1);
    check("fill_game_over", int'(game_over), 1);
    check("fill_count", int'(turn_count), ROWS * COLS);

    // Asynchronous reset in EVAL discards the pending verdict
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 4, 0, 0);
    check("pre_reset_eval", int'(state), 2);
    #2;
    reset = 1'b1; eval_valid = 1'b1; eval_result = 2'd1;
    #1;
    check("async_reset_outputs", int'(dut_vec), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 1);
    check("late_eval_ignored", int'(state), 0);
    check("late_eval_count", int'(turn_count), 0);

`ifdef TURN_TIMEOUT_EN
    do_reset();
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0);
    check("no_timeout_early", int'(timeout_pulse), 0);
    cycle(0, 0, 0, 0, 0);
    check("timeout_pulse", int'(timeout_pulse), 1);
    check("timeout_player", int'(current_player), 1);
    check("timeout_count", int'(turn_count), 0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    check("expiry_move_wins", int'(state), 2);
    check("expiry_no_timeout", int'(timeout_pulse), 0);
`endif

    // Randomized play against the rule model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r, res;
      r = int'($urandom_range(0, 9));
      res = (r == 0) ? 1 : (r == 1) ? 2 : (r < 4) ? 3 : 0;
      cycle(($urandom_range(0, 29) == 0) ? 1 : 0, ($urandom_range(0, 2) != 0) ? 1 : 0,
            int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
